// File: rtl/mem_arbiter_nport.sv
// Round-robin arbiter sharing one multi-cycle memory port among N requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter_nport #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    p_access,
  input  logic [N-1:0]    p_write,
  input  logic [N*AW-1:0] p_a,
  input  logic [N*DW-1:0] p_d_w,
  output logic [N-1:0]    p_ready,
  output logic [DW-1:0]   p_d_r,
  output logic [AW-1:0]   m_a,
  output logic [DW-1:0]   m_d_w,
  output logic            m_access,
  output logic            m_write,
  input  logic            m_ready,
  input  logic [DW-1:0]   m_d_r,
  output logic            err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pick, hi_pick, lo_pick;
  logic          hi_found, lo_found;
  logic          tmo;
  logic          done;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter is 0 in the first BUSY cycle, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign tmo = (state_q == BUSY) && !m_ready && (cnt_q == TW'(TIMEOUT - 1));
  assign err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | tmo;
    if (state_q == IDLE) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign done  = (state_q == BUSY) && (m_ready || tmo);
  assign p_d_r = m_d_r;

  // Lowest requester above last wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (p_access[i]) begin
        if (IW'(i) > last_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_pick  = IW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_pick  = IW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|p_access) begin
          state_d = BUSY;
          gnt_d   = pick;
          last_d  = pick;
        end
      end
      BUSY: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_access = 1'b0;
    m_write  = 1'b0;
    m_a      = '0;
    m_d_w    = '0;
    p_ready  = '0;
    if (state_q == BUSY) begin
      m_access = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (gnt_q == IW'(i)) begin
          m_write    = p_write[i];
          m_a        = p_a[i*AW +: AW];
          m_d_w      = p_d_w[i*DW +: DW];
          p_ready[i] = m_ready || tmo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Directed bench for mem_arbiter_nport (N=4, TIMEOUT=8); timeout case needs ARB_TIMEOUT_EN.
module tb_mem_arbiter_nport;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            clr;
  logic [N-1:0]    p_access;
  logic [N-1:0]    p_write;
  logic [N*AW-1:0] p_a;
  logic [N*DW-1:0] p_d_w;
  logic [N-1:0]    p_ready;
  logic [DW-1:0]   p_d_r;
  logic [AW-1:0]   m_a;
  logic [DW-1:0]   m_d_w;
  logic            m_access;
  logic            m_write;
  logic            m_ready;
  logic [DW-1:0]   m_d_r;
  logic            err;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter_nport #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .clr(clr), .p_access(p_access), .p_write(p_write), .p_a(p_a),
    .p_d_w(p_d_w), .p_ready(p_ready), .p_d_r(p_d_r), .m_a(m_a), .m_d_w(m_d_w),
    .m_access(m_access), .m_write(m_write), .m_ready(m_ready), .m_d_r(m_d_r),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; p_access = '0; p_write = '0; p_a = '0; p_d_w = '0;
    m_ready = 1'b0; m_d_r = '0;
    for (int unsigned i = 0; i < N; i++) p_a[i*AW +: AW] = 32'h1000 + i;
    tick(); tick();
    chk("rst_m_access", m_access, 0);
    chk("rst_p_ready", p_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_m_a", m_a, 0);
    clr = 1'b0;

    // single read on port 0
    p_access = 4'b0001; p_a[0 +: AW] = 32'h40;
    #1;
    chk("rd_no_early_access", m_access, 0);
    tick();
    chk("rd_m_access", m_access, 1);
    chk("rd_m_a", m_a, 32'h40);
    chk("rd_m_write", m_write, 0);
    chk("rd_no_early_ready", p_ready, 0);
    tick(); tick();
    m_ready = 1'b1; m_d_r = 32'hDEADBEEF;
    #1;
    chk("rd_p_ready", p_ready, 4'b0001);
    chk("rd_p_d_r", p_d_r, 32'hDEADBEEF);
    tick();
    m_ready = 1'b0; p_access = '0;
    #1;
    chk("rd_turnaround", m_access, 0);
    chk("rd_ready_once", p_ready, 0);

    // write on port 1
    p_access = 4'b0010; p_write = 4'b0010;
    p_a[1*AW +: AW] = 32'h100; p_d_w[1*DW +: DW] = 32'h12345678;
    tick();
    chk("wr_m_write", m_write, 1);
    chk("wr_m_a", m_a, 32'h100);
    chk("wr_m_d_w", m_d_w, 32'h12345678);
    tick();
    chk("wr_m_write_hold", m_write, 1);
    chk("wr_m_d_w_hold", m_d_w, 32'h12345678);
    m_ready = 1'b1;
    #1;
    chk("wr_p_ready", p_ready, 4'b0010);
    tick();
    m_ready = 1'b0; p_access = '0; p_write = '0;
    #1;
    chk("wr_idle_m_write", m_write, 0);
    chk("wr_idle_m_d_w", m_d_w, 0);
    p_a[0 +: AW] = 32'h1000; p_a[1*AW +: AW] = 32'h1001;

    // contention from fresh reset: order 0,1,2,3,0,1
    clr = 1'b1; tick(); clr = 1'b0;
    p_access = 4'b1111;
    for (int unsigned j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("rr_m_a_%0d", j), m_a, 32'h1000 + (j % 4));
      tick();
      m_ready = 1'b1;
      #1;
      chk($sformatf("rr_p_ready_%0d", j), p_ready, 4'b0001 << (j % 4));
      tick();
      m_ready = 1'b0;
      chk($sformatf("rr_turn_%0d", j), m_access, 0);
    end
    p_access = '0;

    // reset in the middle of a port 2 transaction
    p_access = 4'b0100;
    tick();
    chk("rst_mid_grant2", m_a, 32'h1002);
    clr = 1'b1; p_access = '0;
    tick();
    m_ready = 1'b1;
    #1;
    chk("rst_mid_m_access", m_access, 0);
    chk("rst_mid_p_ready", p_ready, 0);
    clr = 1'b0;
    tick();
    chk("idle_m_ready_ignored", p_ready, 0);
    m_ready = 1'b0; p_access = 4'b1111;
    tick();
    chk("rst_next_grant0", m_a, 32'h1000);
    m_ready = 1'b1;
    #1;
    chk("rst_next_ready0", p_ready, 4'b0001);
    tick();
    m_ready = 1'b0; p_access = '0;

    // request withdrawn mid-transaction
    p_access = 4'b0001;
    tick();
    chk("wd_grant", m_a, 32'h1000);
    p_access = '0;
    tick();
    chk("wd_still_busy", m_access, 1);
    m_ready = 1'b1;
    #1;
    chk("wd_p_ready", p_ready, 4'b0001);
    tick();
    m_ready = 1'b0;
    chk("wd_idle", m_access, 0);

`ifdef ARB_TIMEOUT_EN
    p_access = 4'b0010;
    tick();
    for (int unsigned c = 1; c < 8; c++) begin
      chk($sformatf("to_wait_%0d", c), p_ready, 0);
      tick();
    end
    chk("to_forced_ready", p_ready, 4'b0010);
    chk("to_err_before", err, 0);
    p_access = '0;
    tick();
    chk("to_err_set", err, 1);
    chk("to_idle", m_access, 0);
    tick(); tick();
    chk("to_err_sticky", err, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("to_err_clr", err, 0);
`else
    p_access = 4'b0010;
    tick();
    for (int unsigned c = 0; c < 20; c++) tick();
    chk("nto_still_busy", m_access, 1);
    chk("nto_no_ready", p_ready, 0);
    chk("nto_err", err, 0);
    m_ready = 1'b1; p_access = '0;
    #1;
    chk("nto_p_ready", p_ready, 4'b0010);
    tick();
    m_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_nport.md
Name: mem_arbiter_nport

Overview:
- Round-robin arbiter that multiplexes N core-side memory ports onto one shared memory port (m_a / m_d_r / m_d_w / m_access / m_write / m_ready).
- Generalises the existing two-core shared-memory hookup to any core count and any address/data width.
- Holds a grant for the whole multi-cycle memory transaction.
- Sits between the per-core cache/TLB miss logic and the main memory model.

Parameters:
- N, 2, number of requester ports (2..16).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous reset, active-high.
- p_access  input  N  per-port request; bit i belongs to port i.
- p_write  input  N  per-port write qualifier.
- p_a  input  N*AW  per-port address; port i uses bits [i*AW +: AW].
- p_d_w  input  N*DW  per-port write data; port i uses bits [i*DW +: DW].
- p_ready  output  N  per-port completion strobe.
- p_d_r  output  DW  read data, broadcast to all ports.
- m_a  output  AW  shared memory address.
- m_d_w  output  DW  shared memory write data.
- m_access  output  1  shared memory request.
- m_write  output  1  shared memory write enable.
- m_ready  input  1  shared memory completion.
- m_d_r  input  DW  shared memory read data.
- err  output  1  timeout flag; sticky until reset.

Behaviour:
- States: IDLE, BUSY.
- Reset (clr=1 at a rising edge):
  - state=IDLE, gnt=0, last=N-1, err=0.
  - m_access=0, m_write=0, p_ready=0.
  - Reset mid-transaction abandons the transaction immediately; no p_ready is issued.
- IDLE:
  - If any p_access bit is set, grant the first set bit searching upward from last+1, wrapping at N.
  - Register gnt=index and last=index, then go to BUSY.
  - If no bit is set, stay in IDLE.
- Latency: request seen at edge k, m_access=1 from edge k+1.
- BUSY outputs (combinational):
  - m_access=1.
  - m_write=p_write[gnt].
  - m_a and m_d_w are the granted port's live inputs. The requester holds p_a, p_d_w and p_write stable until it sees p_ready.
- BUSY completion:
  - When m_ready=1, p_ready[gnt]=1 in the same cycle; all other p_ready bits are 0.
  - On the next edge, go to IDLE.
  - This gives one mandatory turnaround cycle with m_access=0 between transactions.
- p_d_r = m_d_r at all times. It is valid for the granted port only while its p_ready is high.
- Outside BUSY: m_access=0, m_write=0, p_ready=0, m_a=0, m_d_w=0.
- Requester drops p_access during BUSY: the transaction still completes, and p_ready is still pulsed.
- Simultaneous requests: exactly one grant per arbitration. A port that is granted cannot be granted again until every other pending port has been served (round-robin fairness).
- Simultaneous m_ready and a new request in the same cycle: the new request waits for the IDLE cycle.
- m_ready while in IDLE: ignored.
- N=1: degenerates to a registered pass-through with one turnaround cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without m_ready, the arbiter forces p_ready[gnt]=1 for one cycle (p_d_r undefined), sets err=1 (sticky), and returns to IDLE.
- Without the macro: no counter, err is tied to 0, and BUSY waits for m_ready indefinitely.

Test Plan:
- Single read: N=2, port0 p_access=1, p_write=0, p_a=0x00000040; memory returns m_ready after 3 cycles with m_d_r=0xDEADBEEF -> m_access rises 1 cycle after the request, m_a=0x40, p_ready=2'b01 for exactly 1 cycle with p_d_r=0xDEADBEEF, then m_access=0 for one cycle.
- Write: port1 p_write=1, p_a=0x100, p_d_w=0x12345678 -> m_write=1, m_a=0x100, m_d_w=0x12345678 throughout BUSY; p_ready=2'b10 on m_ready.
- Contention: N=4, all ports request continuously, m_ready after 2 cycles -> grant order 0,1,2,3,0,1; no port is served twice before the others.
- Reset mid-BUSY: assert clr during a port2 transaction -> next cycle m_access=0, p_ready=0, state=IDLE; the next grant after release is port0.
- Request withdrawn: port0 drops p_access during BUSY -> transaction completes and p_ready[0] still pulses.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): m_ready held at 0 -> forced p_ready pulse after 8 BUSY cycles, err=1 and remains 1 until clr.
